seven_segment_display_scanner: RTL and testbench
================================================

Name: seven_segment_display_scanner

Overview:
- Upstream stage of the seven-segment decoder.
- Holds a DIGITS-wide hex value and time-multiplexes it onto one shared decoder.
- Each step presents one 4-bit nibble (0..15) on the decoder input, plus a one-hot digit-select and a decimal-point bit, which drives the segment h position the decoder leaves unused.
- Provides double-buffered loading, leading-zero blanking and anti-ghosting dead time between digits.

Parameters:
DIGITS, 4, number of multiplexed digits (>=2).
PRESCALE, 50000, clock cycles each digit is lit (>=1).
DEADTIME, 4, cycles all digits are off between digits (>=0).

Ports:
clock  input  1  system clock, rising-edge.
reset_n  input  1  asynchronous, active-low reset.
enable  input  1  scanning on when high.
load  input  1  one-cycle strobe that captures value and dp_in.
value  input  4*DIGITS  hex digits; digit i = value[4i+3:4i], digit 0 rightmost.
dp_in  input  DIGITS  decimal point per digit.
blank_lz  input  1  leading-zero blanking enable, sampled live.
nibble  output  4  code to the decoder input.
digit_en  output  DIGITS  one-hot active-high digit select.
dp  output  1  decimal point for the currently selected digit.
frame_start  output  1  one-cycle pulse when digit 0 is first lit in a frame.

Behaviour:
- One clock domain; reset_n is asynchronous and active-low.
- All outputs are registered.
- Reset state:
  - State IDLE.
  - index 0; counter 0.
  - Shadow and display registers 0; pending 0.
  - nibble=0, digit_en=0, dp=0, frame_start=0.
- Registers:
  - load=1 writes value and dp_in into the shadow register and sets pending.
  - A later load before transfer overwrites the shadow; the last one wins.
- State IDLE:
  - All outputs 0; index held at 0.
  - enable=1 moves to SHOW at the next edge with index 0. That is a frame boundary, so the transfer rule applies.
- State SHOW:
  - Lasts exactly PRESCALE cycles.
  - nibble = display digit[index].
  - dp = display dp[index].
  - digit_en = one-hot(index) unless the digit is blanked, in which case digit_en=0 and dp=0.
- State DEAD:
  - Lasts DEADTIME cycles; with DEADTIME=0 it is skipped and SHOW goes straight to the next SHOW.
  - digit_en=0, dp=0; nibble holds its last value.
- Index advance and frame boundary:
  - The index advances when leaving DEAD, or when leaving SHOW if DEADTIME=0.
  - DIGITS-1 wraps to 0.
  - Frame period = DIGITS*(PRESCALE+DEADTIME) cycles.
- Transfer at a frame boundary (the entry into SHOW with index 0):
  - If pending=1, the display register takes the shadow and pending clears.
  - If load coincides with that boundary edge, the new value bypasses straight into the display register and pending stays 0.
  - Display contents never change mid-frame (no tearing).
- frame_start: 1 on the first SHOW cycle of index 0 in every frame, else 0.
- Leading-zero blanking, when blank_lz=1:
  - Digit i (i>=1) is blanked iff display digits DIGITS-1..i are all 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - A blanked digit still consumes its SHOW time slot.
- enable falls in SHOW or DEAD: return to IDLE at the next edge.
  - Outputs go to 0 and index/counter reset.
  - Shadow, display and pending are kept.
  - Re-enabling starts a fresh frame at digit 0.
- reset_n low at any time:
  - Immediate return to the reset state, independent of the clock.
  - Release is synchronous to the next rising edge.
- Width rules:
  - Counter width = clog2(max(PRESCALE,DEADTIME,2)).
  - Index width = clog2(DIGITS).
  - No arithmetic on value; nibbles pass through unmodified, 0..15.

Test Plan:
(All scenarios use DIGITS=4, PRESCALE=4, DEADTIME=1.)
1. Reset check: assert reset_n=0 mid-SHOW with digit_en=0100 -> same time step digit_en=0000, nibble=0, dp=0, frame_start=0. After release with enable=1, the first lit digit is index 0.
2. Basic scan: load value=16'h1234, dp_in=4'b0100, enable=1, blank_lz=0 ->
   - Repeating pattern of 4 cycles lit + 1 dark.
   - Lit sequence: nibble 4/digit_en 0001, 3/0010, 2/0100 with dp=1, 1/1000.
   - Frame = 20 cycles; frame_start pulses once per 20 cycles.
3. Leading-zero blanking: value=16'h0050, blank_lz=1 -> digits 3 and 2 show digit_en=0000 in their slots; digit 1 shows nibble 5 with 0010; digit 0 shows nibble 0 with 0001. value=16'h0000 -> only digit 0 lit, nibble 0.
4. No tearing: with 16'h1234 displayed, load 16'hABCD while index=2 -> digits 2 and 3 still show 2 and 1 this frame; the next frame shows D,C,B,A. A load on the frame_start edge takes effect in that same frame.
5. Enable drop: enable=0 during the digit-1 slot -> next edge all outputs 0. Re-enable -> digit 0 lit, frame_start=1, contents unchanged.
6. DEADTIME=0, PRESCALE=1 build -> digit_en rotates 0001, 0010, 0100, 1000 every cycle with no dark cycles.

Source files
------------

// File: rtl/seven_segment_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_display_scanner
// Description : Time-multiplexes a DIGITS-wide hex value onto one shared
//               seven-segment decoder. Provides double-buffered loading,
//               leading-zero blanking and dark (anti-ghosting) time between
//               digits.
// Ports       : clock       - system clock, rising edge
//               reset_n     - asynchronous active-low reset
//               enable      - scanning runs while high
//               load        - one-cycle strobe capturing value / dp_in
//               value       - hex digits, digit 0 in value[3:0] (rightmost)
//               dp_in       - decimal point per digit
//               blank_lz    - leading-zero blanking enable (sampled live)
//               nibble      - 4-bit code to the decoder
//               digit_en    - one-hot active-high digit select
//               dp          - decimal point of the selected digit
//               frame_start - pulse on the first lit cycle of digit 0
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_display_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int DEADTIME = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  dp,
  output logic                  frame_start
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_CNT_MAX = (PRESCALE > DEADTIME) ?
                             ((PRESCALE > 2) ? PRESCALE : 2) :
                             ((DEADTIME > 2) ? DEADTIME : 2);
  localparam int c_CNT_W   = $clog2(c_CNT_MAX);
  localparam int c_IDX_W   = $clog2(DIGITS);

  localparam logic [c_CNT_W-1:0] c_SHOW_LAST = c_CNT_W'(PRESCALE - 1);
  localparam logic [c_CNT_W-1:0] c_DEAD_LAST = c_CNT_W'((DEADTIME > 0) ? DEADTIME - 1 : 0);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0]  c_ONE_HOT0  = DIGITS'(1);
  localparam logic               c_HAS_DEAD  = (DEADTIME > 0);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SHOW = 2'd1;
  localparam logic [1:0] c_DEAD = 2'd2;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0]            r_state;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_IDX_W-1:0]    r_idx;

  logic [1:0]            w_state_nxt;
  logic [c_CNT_W-1:0]    w_cnt_nxt;
  logic [c_IDX_W-1:0]    w_idx_nxt;
  logic [c_IDX_W-1:0]    w_idx_inc;
  logic                  w_boundary;      // next edge enters SHOW at index 0

  logic [4*DIGITS-1:0]   r_shadow_val;
  logic [DIGITS-1:0]     r_shadow_dp;
  logic [4*DIGITS-1:0]   r_disp_val;
  logic [DIGITS-1:0]     r_disp_dp;
  logic                  r_pending;

  logic [4*DIGITS-1:0]   w_disp_val_nxt;
  logic [DIGITS-1:0]     w_disp_dp_nxt;

  logic [DIGITS:1]       w_upper_zero;    // digits DIGITS-1..i all zero
  logic [DIGITS-1:0]     w_blank;

  logic [3:0]            w_sel_nib;
  logic                  w_sel_dp;
  logic                  w_sel_blank;

  logic [3:0]            w_nibble_nxt;
  logic [DIGITS-1:0]     w_digit_en_nxt;
  logic                  w_dp_nxt;
  logic                  w_frame_start_nxt;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Explicit wrap so non-power-of-two DIGITS never visits unused indices.
  assign w_idx_inc = (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_boundary  = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (enable) begin
          w_state_nxt = c_SHOW;
          w_boundary  = 1'b1;
        end
      end
      c_SHOW: begin
        if (!enable) begin
          w_state_nxt = c_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else if (r_cnt == c_SHOW_LAST) begin
          w_cnt_nxt = '0;
          if (c_HAS_DEAD) begin
            w_state_nxt = c_DEAD;
          end else begin
            // No dark time: step straight to the next digit.
            w_state_nxt = c_SHOW;
            w_idx_nxt   = w_idx_inc;
            w_boundary  = (r_idx == c_IDX_LAST);
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      c_DEAD: begin
        if (!enable) begin
          w_state_nxt = c_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else if (r_cnt == c_DEAD_LAST) begin
          w_state_nxt = c_SHOW;
          w_cnt_nxt   = '0;
          w_idx_nxt   = w_idx_inc;
          w_boundary  = (r_idx == c_IDX_LAST);
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Double buffer. The display register only changes on a frame boundary,
  // so a frame is never drawn from two different values. A load on the
  // boundary edge itself bypasses the shadow and is shown immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    w_disp_val_nxt = r_disp_val;
    w_disp_dp_nxt  = r_disp_dp;
    if (w_boundary) begin
      if (load) begin
        w_disp_val_nxt = value;
        w_disp_dp_nxt  = dp_in;
      end else if (r_pending) begin
        w_disp_val_nxt = r_shadow_val;
        w_disp_dp_nxt  = r_shadow_dp;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (load) begin
        r_shadow_val <= value;
        r_shadow_dp  <= dp_in;
      end
      if (w_boundary) begin
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
      r_disp_val <= w_disp_val_nxt;
      r_disp_dp  <= w_disp_dp_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Leading-zero detection on the contents about to be displayed.
  // Digit 0 is never blanked so an all-zero value still shows one "0".
  // --------------------------------------------------------------------------
  assign w_upper_zero[DIGITS] = 1'b1;
  assign w_blank[0]           = 1'b0;

  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
    assign w_upper_zero[gi] = (w_disp_val_nxt[4*gi +: 4] == 4'd0) && w_upper_zero[gi+1];
    assign w_blank[gi]      = blank_lz && w_upper_zero[gi];
  end

  // Select the digit addressed by the next index.
  always_comb begin
    w_sel_nib   = 4'd0;
    w_sel_dp    = 1'b0;
    w_sel_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_idx_nxt == c_IDX_W'(i)) begin
        w_sel_nib   = w_disp_val_nxt[4*i +: 4];
        w_sel_dp    = w_disp_dp_nxt[i];
        w_sel_blank = w_blank[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: output logic. Outputs are decoded from the next state and then
  // registered, so they line up with the state register.
  // --------------------------------------------------------------------------
  always_comb begin
    w_nibble_nxt      = 4'd0;
    w_digit_en_nxt    = '0;
    w_dp_nxt          = 1'b0;
    w_frame_start_nxt = 1'b0;
    case (w_state_nxt)
      c_SHOW: begin
        w_nibble_nxt      = w_sel_nib;
        w_frame_start_nxt = w_boundary;
        if (!w_sel_blank) begin
          w_digit_en_nxt = c_ONE_HOT0 << w_idx_nxt;
          w_dp_nxt       = w_sel_dp;
        end
      end
      c_DEAD: begin
        // Keep the decoder input steady while all digits are dark.
        w_nibble_nxt = nibble;
      end
      default: begin
        w_nibble_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      nibble      <= 4'd0;
      digit_en    <= '0;
      dp          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      nibble      <= w_nibble_nxt;
      digit_en    <= w_digit_en_nxt;
      dp          <= w_dp_nxt;
      frame_start <= w_frame_start_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_display_scanner
// Description : Self-checking bench for seven_segment_display_scanner.
//               A timeline model (cycles since scanning started) predicts
//               every output; a second instance covers PRESCALE=1/DEADTIME=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_display_scanner;

  localparam int DIG   = 4;
  localparam int P     = 4;
  localparam int D     = 1;
  localparam int FRAME = DIG * (P + D);

  logic        clock    = 1'b0;
  logic        reset_n  = 1'b0;
  logic        enable   = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] value    = 16'h0;
  logic [3:0]  dp_in    = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  nibble;
  logic [3:0]  digit_en;
  logic        dp;
  logic        frame_start;

  logic        enable2   = 1'b0;
  logic        load2     = 1'b0;
  logic [15:0] value2    = 16'h0;
  logic [3:0]  dp_in2    = 4'h0;
  logic [3:0]  nibble2;
  logic [3:0]  digit_en2;
  logic        dp2;
  logic        frame_start2;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          m_t;
  logic [15:0] m_shadow, m_disp;
  logic [3:0]  m_sdp, m_ddp;
  logic        m_pend;
  logic [3:0]  m_last;
  logic [3:0]  e_nib;
  logic [3:0]  e_en;
  logic        e_dp, e_fs;

  seven_segment_display_scanner #(.DIGITS(DIG), .PRESCALE(P), .DEADTIME(D)) u_dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .load(load),
    .value(value), .dp_in(dp_in), .blank_lz(blank_lz),
    .nibble(nibble), .digit_en(digit_en), .dp(dp), .frame_start(frame_start)
  );

  seven_segment_display_scanner #(.DIGITS(4), .PRESCALE(1), .DEADTIME(0)) u_fast (
    .clock(clock), .reset_n(reset_n), .enable(enable2), .load(load2),
    .value(value2), .dp_in(dp_in2), .blank_lz(1'b0),
    .nibble(nibble2), .digit_en(digit_en2), .dp(dp2), .frame_start(frame_start2)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic string outs(input logic [3:0] n, input logic [3:0] en,
                                 input logic d, input logic fs);
    return $sformatf("nib=%h en=%b dp=%b fs=%b", n, en, d, fs);
  endfunction

  task automatic model_reset();
    m_t = -1; m_shadow = 0; m_disp = 0; m_sdp = 0; m_ddp = 0; m_pend = 0;
    m_last = 0; e_nib = 0; e_en = 0; e_dp = 0; e_fs = 0;
  endtask

  // Predicts the outputs after a rising edge from the inputs seen at that edge.
  task automatic model_edge();
    int slot, dg;
    logic bnd, blanked;
    if (!reset_n) begin
      model_reset();
    end else begin
      m_t = enable ? m_t + 1 : -1;
      bnd = enable && (m_t % FRAME == 0);
      if (bnd) begin
        if (load) begin
          m_disp = value; m_ddp = dp_in; m_shadow = value; m_sdp = dp_in; m_pend = 0;
        end else if (m_pend) begin
          m_disp = m_shadow; m_ddp = m_sdp; m_pend = 0;
        end
      end else if (load) begin
        m_shadow = value; m_sdp = dp_in; m_pend = 1;
      end
      if (m_t < 0) begin
        e_nib = 0; e_en = 0; e_dp = 0; e_fs = 0; m_last = 0;
      end else begin
        slot = m_t % (P + D);
        dg   = (m_t / (P + D)) % DIG;
        if (slot < P) begin
          e_nib   = m_disp[4*dg +: 4];
          blanked = blank_lz && (dg >= 1) && ((m_disp >> (4*dg)) == 16'h0);
          e_en    = blanked ? 4'b0 : 4'(1 << dg);
          e_dp    = blanked ? 1'b0 : m_ddp[dg];
          e_fs    = bnd;
          m_last  = e_nib;
        end else begin
          e_nib = m_last; e_en = 0; e_dp = 0; e_fs = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    bit found = 0;
    #1;
    n_cmp++;
    if ({nibble, digit_en, dp, frame_start} !== 10'b0) begin
      n_err++; $display("FAIL reset_state: got %s want all zero", outs(nibble, digit_en, dp, frame_start));
    end
    model_reset();
    repeat (2) step();
    reset_n = 1; enable = 1;
    for (int k = 0; k < 50 && !found; k++) begin
      step();
      n_cmp++;
      if ({nibble, digit_en, dp, frame_start} !== {e_nib, e_en, e_dp, e_fs}) begin
        n_err++; $display("FAIL reset_run: got %s want %s", outs(nibble, digit_en, dp, frame_start), outs(e_nib, e_en, e_dp, e_fs));
      end
      if (e_en == 4'b0100) found = 1;
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL reset_reach_digit2: got not found want found"); end
    #2 reset_n = 0;
    #1;
    n_cmp++;
    if ({nibble, digit_en, dp, frame_start} !== 10'b0) begin
      n_err++; $display("FAIL reset_async: got %s want all zero", outs(nibble, digit_en, dp, frame_start));
    end
    model_reset();
    step();
    reset_n = 1;
    step();
    n_cmp++;
    if (digit_en !== 4'b0001 || frame_start !== 1'b1 || nibble !== 4'h0) begin
      n_err++; $display("FAIL reset_first_digit: got %s want nib=0 en=0001 fs=1", outs(nibble, digit_en, dp, frame_start));
    end
  endtask

  task automatic test_basic_scan();
    int fs_cnt = 0;
    blank_lz = 0; value = 16'h1234; dp_in = 4'b0100; load = 1;
    step();
    load = 0;
    for (int k = 0; k < 70; k++) begin
      step();
      n_cmp++;
      if ({nibble, digit_en, dp, frame_start} !== {e_nib, e_en, e_dp, e_fs}) begin
        n_err++; $display("FAIL basic_scan: got %s want %s", outs(nibble, digit_en, dp, frame_start), outs(e_nib, e_en, e_dp, e_fs));
      end
      if (k >= 30 && frame_start === 1'b1) fs_cnt++;
    end
    n_cmp++;
    if (fs_cnt != 2) begin n_err++; $display("FAIL frame_period: got %0d pulses want 2 in 40 cycles", fs_cnt); end
  endtask

  task automatic test_blanking();
    blank_lz = 1;
    for (int v = 0; v < 2; v++) begin
      value = (v == 0) ? 16'h0050 : 16'h0000; dp_in = 4'b1111; load = 1;
      step();
      load = 0;
      for (int k = 0; k < 45; k++) begin
        step();
        n_cmp++;
        if ({nibble, digit_en, dp, frame_start} !== {e_nib, e_en, e_dp, e_fs}) begin
          n_err++; $display("FAIL blanking: got %s want %s", outs(nibble, digit_en, dp, frame_start), outs(e_nib, e_en, e_dp, e_fs));
        end
      end
    end
    blank_lz = 0;
  endtask

  task automatic test_no_tearing();
    bit found = 0;
    value = 16'h1234; dp_in = 4'b0; load = 1;
    step();
    load = 0;
    for (int k = 0; k < 100 && !(k > 40 && e_en == 4'b0100); k++) begin
      step();
      n_cmp++;
      if ({nibble, digit_en, dp, frame_start} !== {e_nib, e_en, e_dp, e_fs}) begin
        n_err++; $display("FAIL tear_setup: got %s want %s", outs(nibble, digit_en, dp, frame_start), outs(e_nib, e_en, e_dp, e_fs));
      end
    end
    value = 16'hABCD; dp_in = 4'($urandom); load = 1;
    step();
    load = 0;
    for (int k = 0; k < 45; k++) begin
      n_cmp++;
      if ({nibble, digit_en, dp, frame_start} !== {e_nib, e_en, e_dp, e_fs}) begin
        n_err++; $display("FAIL no_tearing: got %s want %s", outs(nibble, digit_en, dp, frame_start), outs(e_nib, e_en, e_dp, e_fs));
      end
      step();
    end
    for (int k = 0; k < 30 && !found; k++) begin
      if ((m_t + 1) % FRAME == 0) found = 1;
      else step();
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL boundary_search: got not found want found"); end
    value = 16'h5A5A; load = 1;
    step();
    load = 0;
    n_cmp++;
    if (nibble !== 4'hA || digit_en !== 4'b0001 || frame_start !== 1'b1) begin
      n_err++; $display("FAIL boundary_load: got %s want nib=a en=0001 fs=1", outs(nibble, digit_en, dp, frame_start));
    end
    for (int k = 0; k < 25; k++) begin
      step();
      n_cmp++;
      if ({nibble, digit_en, dp, frame_start} !== {e_nib, e_en, e_dp, e_fs}) begin
        n_err++; $display("FAIL boundary_frame: got %s want %s", outs(nibble, digit_en, dp, frame_start), outs(e_nib, e_en, e_dp, e_fs));
      end
    end
  endtask

  task automatic test_enable_drop();
    for (int k = 0; k < 30 && e_en != 4'b0010; k++) step();
    n_cmp++;
    if (digit_en !== 4'b0010) begin n_err++; $display("FAIL drop_setup: got en=%b want en=0010", digit_en); end
    enable = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if ({nibble, digit_en, dp, frame_start} !== 10'b0) begin
        n_err++; $display("FAIL enable_drop: got %s want all zero", outs(nibble, digit_en, dp, frame_start));
      end
    end
    enable = 1;
    step();
    n_cmp++;
    if (digit_en !== 4'b0001 || frame_start !== 1'b1 || nibble !== 4'hA) begin
      n_err++; $display("FAIL re_enable: got %s want nib=a en=0001 fs=1", outs(nibble, digit_en, dp, frame_start));
    end
    for (int k = 0; k < 25; k++) begin
      step();
      n_cmp++;
      if ({nibble, digit_en, dp, frame_start} !== {e_nib, e_en, e_dp, e_fs}) begin
        n_err++; $display("FAIL re_enable_frame: got %s want %s", outs(nibble, digit_en, dp, frame_start), outs(e_nib, e_en, e_dp, e_fs));
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      load   = ($urandom_range(0, 7) == 0);
      value  = 16'($urandom);
      if ($urandom_range(0, 1) == 0) value[15:8] = 8'h00;
      dp_in  = 4'($urandom);
      enable = ($urandom_range(0, 60) != 0);
      if ($urandom_range(0, 40) == 0) blank_lz = ~blank_lz;
      step();
      n_cmp++;
      if ({nibble, digit_en, dp, frame_start} !== {e_nib, e_en, e_dp, e_fs}) begin
        n_err++; $display("FAIL random: got %s want %s", outs(nibble, digit_en, dp, frame_start), outs(e_nib, e_en, e_dp, e_fs));
      end
    end
    load = 0; enable = 1;
  endtask

  task automatic test_fast_build();
    value2 = 16'($urandom); dp_in2 = 4'($urandom); load2 = 1; enable2 = 1;
    step();
    load2 = 0;
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if ({nibble2, digit_en2, dp2, frame_start2} !==
          {value2[4*(k%4) +: 4], 4'(1 << (k % 4)), dp_in2[k%4], (k % 4 == 0)}) begin
        n_err++; $display("FAIL fast_rotate k=%0d: got %s want nib=%h en=%b", k,
                          outs(nibble2, digit_en2, dp2, frame_start2), value2[4*(k%4) +: 4], 4'(1 << (k % 4)));
      end
      step();
    end
    enable2 = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_scan();
    test_blanking();
    test_no_tearing();
    test_enable_drop();
    test_random();
    test_fast_build();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
